// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : Raster timing generator for a 640x480@60 VGA output.
//                Produces hpos/vpos counters, hsync/vsync, display_on and
//                line/frame/move strobes. Every output is registered and is
//                decoded from the next-state counters, so all outputs refer
//                to the same pixel as hpos/vpos in the same cycle.
//  Ports       : clk        - pixel clock
//                rst_n      - asynchronous active-low reset
//                hpos       - current column, 0..H_TOTAL-1
//                vpos       - current line, 0..V_TOTAL-1
//                hsync      - horizontal sync (active level = SYNC_POL)
//                vsync      - vertical sync (active level = SYNC_POL)
//                display_on - inside the visible area
//                line_tick  - 1-cycle pulse at hpos==0
//                frame_tick - 1-cycle pulse at (0, V_DISPLAY), start of v-blank
//                move_tick  - 1-cycle pulse on every MOVE_DIV-th frame_tick
//                frame_cnt  - frame counter (see macro below)
//  Macro       : VGA_TIMING_FRAME_CNT_EN - when defined, frame_cnt counts
//                frame_ticks and wraps 255->0; otherwise it is tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter bit          SYNC_POL  = 1'b0,
    parameter int unsigned MOVE_DIV  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic       line_tick,
    output logic       frame_tick,
    output logic       move_tick,
    output logic [7:0] frame_cnt
);

    localparam int unsigned c_H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned c_V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] c_H_LAST     = 10'(c_H_TOTAL - 1);
    localparam logic [9:0] c_V_LAST     = 10'(c_V_TOTAL - 1);
    localparam logic [9:0] c_H_DISP     = 10'(H_DISPLAY);
    localparam logic [9:0] c_V_DISP     = 10'(V_DISPLAY);
    localparam logic [9:0] c_HS_FIRST   = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] c_HS_LAST    = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] c_VS_FIRST   = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] c_VS_LAST    = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam logic [7:0] c_MOVE_LAST  = 8'(MOVE_DIV - 1);

    // Reject geometries that do not fit the 10-bit counters or the 8-bit divider.
    generate
        if (c_H_TOTAL > 1024 || c_V_TOTAL > 1024 || MOVE_DIV < 1 || MOVE_DIV > 255) begin : g_bad_params
            $error("vga_timing_gen: illegal parameters (H_TOTAL=%0d V_TOTAL=%0d MOVE_DIV=%0d)",
                   c_H_TOTAL, c_V_TOTAL, MOVE_DIV);
        end
    endgenerate

    logic       w_h_wrap;
    logic [9:0] w_h_nxt;
    logic [9:0] w_v_nxt;
    logic       w_frame_nxt;
    logic [7:0] r_move_div;

    // Next-state counters; all registered outputs are decoded from these so
    // they line up with hpos/vpos once loaded.
    always_comb begin
        w_h_wrap = (hpos == c_H_LAST);
        w_h_nxt  = w_h_wrap ? 10'd0 : hpos + 10'd1;
        w_v_nxt  = vpos;
        if (w_h_wrap) begin
            w_v_nxt = (vpos == c_V_LAST) ? 10'd0 : vpos + 10'd1;
        end
        w_frame_nxt = (w_h_nxt == 10'd0) && (w_v_nxt == c_V_DISP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Parked on the last pixel so the first edge lands on (0,0).
            hpos       <= c_H_LAST;
            vpos       <= c_V_LAST;
            hsync      <= ~SYNC_POL;
            vsync      <= ~SYNC_POL;
            display_on <= 1'b0;
            line_tick  <= 1'b0;
            frame_tick <= 1'b0;
            move_tick  <= 1'b0;
            r_move_div <= 8'd0;
        end else begin
            hpos       <= w_h_nxt;
            vpos       <= w_v_nxt;
            hsync      <= (w_h_nxt >= c_HS_FIRST && w_h_nxt <= c_HS_LAST) ? SYNC_POL : ~SYNC_POL;
            vsync      <= (w_v_nxt >= c_VS_FIRST && w_v_nxt <= c_VS_LAST) ? SYNC_POL : ~SYNC_POL;
            display_on <= (w_h_nxt < c_H_DISP) && (w_v_nxt < c_V_DISP);
            line_tick  <= (w_h_nxt == 10'd0);
            frame_tick <= w_frame_nxt;
            move_tick  <= 1'b0;
            if (w_frame_nxt) begin
                // move_tick rides on the frame_tick that completes the divide.
                if (r_move_div == c_MOVE_LAST) begin
                    r_move_div <= 8'd0;
                    move_tick  <= 1'b1;
                end else begin
                    r_move_div <= r_move_div + 8'd1;
                end
            end
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [7:0] r_frame_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= 8'd0;
        end else if (w_frame_nxt) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`else
    assign frame_cnt = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_timing_gen
//  Description : Self-checking bench for vga_timing_gen. Two instances share
//                clock and reset: one with MOVE_DIV=2 / active-low sync, one
//                with MOVE_DIV=1 / active-high sync. A reduced raster keeps
//                frames short. Expected outputs come from an arithmetic model
//                of pixel position derived from edges since reset release.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    localparam int HD = 8, HF = 1, HS = 2, HB = 1;
    localparam int VD = 6, VF = 1, VS = 2, VB = 1;
    localparam int HT = HD + HF + HS + HB;   // 12
    localparam int VT = VD + VF + VS + VB;   // 10
    localparam int FT = HT * VT;             // 120 clocks per frame

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic [9:0] hpos_a, vpos_a, hpos_b, vpos_b;
    logic       hsync_a, vsync_a, disp_a, line_a, frame_a, move_a;
    logic       hsync_b, vsync_b, disp_b, line_b, frame_b, move_b;
    logic [7:0] fcnt_a, fcnt_b;

    int checks   = 0;
    int failures = 0;

    // Model state: n = edges since release (first edge is n=0), frames = frame_ticks seen.
    bit in_reset = 1'b1;
    int n        = -1;
    int frames   = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_POL(1'b0), .MOVE_DIV(2)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .hpos(hpos_a), .vpos(vpos_a),
        .hsync(hsync_a), .vsync(vsync_a), .display_on(disp_a),
        .line_tick(line_a), .frame_tick(frame_a), .move_tick(move_a),
        .frame_cnt(fcnt_a)
    );

    vga_timing_gen #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_POL(1'b1), .MOVE_DIV(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .hpos(hpos_b), .vpos(vpos_b),
        .hsync(hsync_b), .vsync(vsync_b), .display_on(disp_b),
        .line_tick(line_b), .frame_tick(frame_b), .move_tick(move_b),
        .frame_cnt(fcnt_b)
    );

    // Expected output vector {hpos,vpos,hsync,vsync,display_on,line,frame,move,frame_cnt}.
    function automatic logic [33:0] expect_vec(input bit pol, input int div);
        int p, h, v;
        bit hs_act, vs_act, disp, ln, ft, mv;
        logic [7:0] fc;
        if (in_reset) return {10'(HT - 1), 10'(VT - 1), ~pol, ~pol, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        p      = n % FT;
        h      = p % HT;
        v      = p / HT;
        hs_act = (h >= HD + HF) && (h < HD + HF + HS);
        vs_act = (v >= VD + VF) && (v < VD + VF + VS);
        disp   = (h < HD) && (v < VD);
        ln     = (h == 0);
        ft     = (h == 0) && (v == VD);
        mv     = ft && ((frames % div) == 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
        fc     = 8'(frames % 256);
`else
        fc     = 8'd0;
`endif
        return {10'(h), 10'(v), hs_act ? pol : ~pol, vs_act ? pol : ~pol,
                disp, ln, ft, mv, fc};
    endfunction

    task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s n=%0d observed=%h expected=%h", tag, n, obs, exp);
        end
    endtask

    task automatic check_both();
        check("dut_a", {hpos_a, vpos_a, hsync_a, vsync_a, disp_a, line_a, frame_a, move_a, fcnt_a},
              expect_vec(1'b0, 2));
        check("dut_b", {hpos_b, vpos_b, hsync_b, vsync_b, disp_b, line_b, frame_b, move_b, fcnt_b},
              expect_vec(1'b1, 1));
    endtask

    // One clock edge: advance the model, then sample 1 time unit after the edge.
    task automatic step();
        int p;
        @(posedge clk);
        if (!in_reset) begin
            n++;
            p = n % FT;
            if (p == VD * HT) frames++;
        end
        #1;
        check_both();
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    // Drop reset between edges and confirm the outputs change without a clock.
    task automatic async_reset(input int hold);
        #($urandom_range(1, 6));
        rst_n    = 1'b0;
        in_reset = 1'b1;
        n        = -1;
        frames   = 0;
        #1;
        check_both();
        run(hold);
        @(negedge clk);
        rst_n    = 1'b0;
        rst_n    = 1'b1;
        in_reset = 1'b0;
    endtask

    initial begin
        // Reset state.
        run(3);
        @(negedge clk);
        rst_n    = 1'b1;
        in_reset = 1'b0;

        // Three full frames from release: lines, syncs, frame and move ticks.
        run(3 * FT + 5);

        // Directed mid-frame reset at (5,3); restart from (0,0), divider phase lost.
        while ((n % FT) != 3 * HT + 5) step();
        async_reset(2);
        run(2 * FT);

        // Randomized run lengths and reset points.
        for (int k = 0; k < 6; k++) begin
            run($urandom_range(20, 700));
            async_reset($urandom_range(1, 4));
        end

        // 257 frames without reset: frame_cnt wraps to 1 when counting is enabled.
        run(257 * FT + 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
